wb_regfile: RTL

- Consumer end of the MEM/WB pipeline register in the 5-stage RV32I core.
- Selects the writeback value from the registered MEM-stage results and writes it into the 32x32 architectural register file.
- Serves two combinational read ports to the decode stage, with write-first bypass.
- Keeps a retired-instruction counter and the PC of the last retired instruction for debug.

---
 rtl/wb_regfile.sv | 96 +++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage of the 5-stage RV32I core.
// Selects the writeback value from the MEM/WB register, writes the 32x32
// architectural register file and serves two write-first read ports to decode.
// Optional macro WB_INSTRET_EN: when defined, a 64-bit retired-instruction
// counter and the last retired PC are kept; otherwise both read as zero.
module wb_regfile #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_SP = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_write_mem_pp,
  input  logic [1:0]      mem_reg_mem_pp,
  input  logic [XLEN-1:0] alu_res_mem_pp,
  input  logic [XLEN-1:0] wrap_load_mem_pp,
  input  logic [XLEN-1:0] next_sel_address_mem_pp,
  input  logic [31:0]     instruction_mem_pp,
  input  logic [XLEN-1:0] pre_address_mem_pp,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic [63:0]     instret,
  output logic [XLEN-1:0] retire_pc
);

  logic [XLEN-1:0] regs [32];

  // Writeback source select; the reserved encoding falls back to the ALU result
  always_comb begin
    wb_data = alu_res_mem_pp;
    case (mem_reg_mem_pp)
      2'b01:   wb_data = wrap_load_mem_pp;
      2'b10:   wb_data = next_sel_address_mem_pp;
      default: wb_data = alu_res_mem_pp;
    endcase
  end

  assign wb_rd = instruction_mem_pp[11:7];
  assign wb_we = reg_write_mem_pp & (wb_rd != 5'd0) & ~rst;

  // Register array: reset loads x2 with the stack pointer, writes gated by wb_we
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= (i == 2) ? RESET_SP[XLEN-1:0] : '0;
      end
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Read ports: x0 hardwired, same-cycle write forwarded (wb_we is low in reset)
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (wb_we && (wb_rd == rs1_addr)) begin
      rs1_data = wb_data;
    end
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (wb_we && (wb_rd == rs2_addr)) begin
      rs2_data = wb_data;
    end
  end

`ifdef WB_INSTRET_EN
  logic retire;
  assign retire = (instruction_mem_pp != 32'h0) & ~rst;

  // Retire bookkeeping: every non-bubble slot counts, independent of reg_write
  always_ff @(posedge clk) begin
    if (rst) begin
      instret   <= '0;
      retire_pc <= '0;
    end else if (retire) begin
      instret   <= instret + 64'd1;
      retire_pc <= pre_address_mem_pp;
    end
  end
`else
  assign instret   = '0;
  assign retire_pc = '0;

  // Only the rd field of the instruction and no PC are needed without the counter
  logic unused_retire;
  assign unused_retire = ^{pre_address_mem_pp, instruction_mem_pp[31:12],
                           instruction_mem_pp[6:0]};
`endif

endmodule
